// File: rtl/posit_encode_seq.sv
// posit_encode_seq: sequential posit encoder.
//
// Takes a sign, a signed total scale (k*2^es + e) and an MSB-aligned fraction.
// It builds the regime by shifting a 2N-bit working register one bit per cycle,
// then rounds to nearest-even and applies the sign.
//
// Optional feature macro: POSIT_ENC_OVF_FLAG_EN adds the ovf output.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   sign     in   value sign
//   scale    in   [SW-1:0] signed total scale
//   frac     in   [N-1:0] fraction below the hidden 1, MSB-aligned
//   zero_in  in   zero value flag
//   inf_in   in   NaR flag, has priority over zero_in
//   out      out  [N-1:0] encoded posit, held between results
//   busy     out  high whenever the FSM is not in IDLE
//   done     out  one-cycle pulse, out is valid in the same cycle
//   ovf      out  (macro only) saturation or clamp happened, valid with done
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; captures inputs and loads W
// SHIFT | shifts regime fill into W, one bit per cycle, R cycles total
// ROUND | rounds / saturates and loads out
// FIN   | done high, out valid; returns to IDLE on the next edge

module posit_encode_seq #(
    parameter int N  = 32,
    parameter int es = 2,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          sign,
    input  logic [SW-1:0] scale,
    input  logic [N-1:0]  frac,
    input  logic          zero_in,
    input  logic          inf_in,
    output logic [N-1:0]  out,
    output logic          busy,
    output logic          done
`ifdef POSIT_ENC_OVF_FLAG_EN
    ,
    output logic          ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ROUND = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic signed [SW:0] W_ONE  = {{SW{1'b0}}, 1'b1};
    localparam logic [SW:0]        CNT_1  = {{SW{1'b0}}, 1'b1};
    localparam logic [SW:0]        R_LIM  = (SW+1)'(N-1);
    localparam logic [N-2:0]       B_MIN  = {{(N-2){1'b0}}, 1'b1};
    localparam logic [N-2:0]       B_MAX  = {(N-1){1'b1}};

    state_t r_state;
    state_t w_state_nxt;

    logic [2*N-1:0] r_w;
    logic [SW:0]    r_cnt;
    logic           r_sign;
    logic           r_neg;
    logic           r_sat;
    logic [N-1:0]   r_out;

    // Scale decode: k = scale >>> es, run length R of the regime.
    logic signed [SW-1:0] w_k;
    logic signed [SW:0]   w_kx;
    logic [SW:0]          w_r;
    logic                 w_neg;
    logic                 w_sat_in;
    logic                 w_special;
    logic                 w_accept;

    assign w_k       = $signed(scale) >>> es;
    assign w_kx      = {w_k[SW-1], w_k};
    assign w_neg     = w_k[SW-1];
    assign w_r       = w_neg ? -w_kx : (w_kx + W_ONE);
    assign w_sat_in  = (w_r > R_LIM);
    assign w_special = inf_in | zero_in;
    assign w_accept  = (r_state == S_IDLE) & start;

    // Rounding on the shifted register.
    logic [N-2:0] w_body;
    logic         w_guard;
    logic         w_sticky;
    logic         w_inc;
    logic [N-1:0] w_sum;
    logic [N-2:0] w_body_fin;
    logic [N-1:0] w_mag;
    logic [N-1:0] w_res;

    assign w_body   = r_w[2*N-1:N+1];
    assign w_guard  = r_w[N];
    assign w_sticky = |r_w[N-1:0];
    assign w_inc    = w_guard & (w_sticky | w_body[0]);
    assign w_sum    = {1'b0, w_body} + {{(N-1){1'b0}}, w_inc};

    // A carry out of the body or a zero body must not reach NaR / zero.
    always_comb begin
        w_body_fin = w_sum[N-2:0];
        if (r_sat) begin
            w_body_fin = r_neg ? B_MIN : B_MAX;
        end else if (w_sum[N-1]) begin
            w_body_fin = B_MAX;
        end else if (w_sum[N-2:0] == '0) begin
            w_body_fin = B_MIN;
        end
    end

    assign w_mag = {1'b0, w_body_fin};
    assign w_res = r_sign ? -w_mag : w_mag;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_special) begin
                        w_state_nxt = S_FIN;
                    end else if (w_sat_in) begin
                        w_state_nxt = S_ROUND;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_1) begin
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_FIN);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w    <= '0;
            r_cnt  <= '0;
            r_sign <= 1'b0;
            r_neg  <= 1'b0;
            r_sat  <= 1'b0;
            r_out  <= '0;
        end else if (w_accept) begin
            r_sign <= sign;
            r_neg  <= w_neg;
            r_sat  <= w_sat_in & ~w_special;
            // term bit is the regime terminator: 0 after ones, 1 after zeros
            r_w    <= {w_neg, scale[es-1:0], frac, {(N-1-es){1'b0}}};
            r_cnt  <= w_r;
            if (inf_in) begin
                r_out <= {1'b1, {(N-1){1'b0}}};
            end else if (zero_in) begin
                r_out <= '0;
            end
        end else if (r_state == S_SHIFT) begin
            r_w   <= {~r_neg, r_w[2*N-1:1]};
            r_cnt <= r_cnt - CNT_1;
        end else if (r_state == S_ROUND) begin
            r_out <= w_res;
        end
    end

    assign out = r_out;

`ifdef POSIT_ENC_OVF_FLAG_EN
    logic r_ovf;
    logic w_clamp;

    assign w_clamp = ~r_sat & (w_sum[N-1] | (w_sum[N-2:0] == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_ROUND) begin
            r_ovf <= r_sat | w_clamp;
        end
    end

    assign ovf = r_ovf & done;
`else
    // No overflow flag: saturation and clamping above still apply.
`endif

endmodule

// File: tb/tb_posit_encode_seq.sv
module tb_posit_encode_seq;

    localparam int N  = 32;
    localparam int ES = 2;
    localparam int SW = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          sign    = 1'b0;
    logic [SW-1:0] scale   = '0;
    logic [N-1:0]  frac    = '0;
    logic          zero_in = 1'b0;
    logic          inf_in  = 1'b0;
    logic [N-1:0]  out;
    logic          busy;
    logic          done;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    posit_encode_seq #(.N(N), .es(ES), .SW(SW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sign    (sign),
        .scale   (scale),
        .frac    (frac),
        .zero_in (zero_in),
        .inf_in  (inf_in),
        .out     (out),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: write the posit as a bit string (regime run, terminator,
    // exponent, fraction), cut it at N-1 bits and round the integer.
    function automatic logic [31:0] ref_enc(input logic s, input logic [7:0] sc,
                                            input logic [31:0] fr, input logic z,
                                            input logic i, output int lat);
        int          scl;
        int          k;
        int          e;
        int          r;
        int          p;
        logic [95:0] bits;
        logic [30:0] body;
        logic        g;
        logic        st;
        longint      m;
        if (i) begin
            lat = 2;
            return 32'h80000000;
        end
        if (z) begin
            lat = 2;
            return 32'h00000000;
        end
        scl = $signed(sc);
        k   = (scl >= 0) ? scl / 4 : -((-scl + 3) / 4);
        e   = scl - 4 * k;
        r   = (k >= 0) ? k + 1 : -k;
        if (r > N - 1) begin
            lat = 3;
            m   = (k >= 0) ? 64'h7FFFFFFF : 64'h1;
        end else begin
            bits = '0;
            p    = 95;
            for (int j = 0; j < r; j++) begin
                bits[p] = (k >= 0);
                p--;
            end
            bits[p] = (k < 0);
            p--;
            bits[p] = e[1];
            p--;
            bits[p] = e[0];
            p--;
            for (int j = 31; j >= 0; j--) begin
                bits[p] = fr[j];
                p--;
            end
            body = bits[95:65];
            g    = bits[64];
            st   = |bits[63:0];
            m    = longint'(body) + ((g && (st || body[0])) ? 64'd1 : 64'd0);
            if (m > 64'h7FFFFFFF) m = 64'h7FFFFFFF;
            if (m == 0) m = 1;
            lat = r + 3;
        end
        return s ? 32'(-m) : 32'(m);
    endfunction

    // One transaction; lat counts edges from the accepting edge (as 1) to the
    // edge at which done is seen high.
    task automatic run_op(input logic s, input logic [7:0] sc, input logic [31:0] fr,
                          input logic z, input logic i, input string tag,
                          output logic [31:0] o, output int lat);
        logic got;
        @(negedge clk);
        sign    = s;
        scale   = sc;
        frac    = fr;
        zero_in = z;
        inf_in  = i;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 2;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!got) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            lat = -1;
        end
        o = out;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_out_hold"}, out, o);
    endtask

    typedef struct {
        logic        s;
        logic [7:0]  sc;
        logic [31:0] fr;
        logic        z;
        logic        i;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        dir[13];
    logic [31:0] o;
    logic [31:0] e_out;
    int          lat;
    int          e_lat;
    int          cnt;

    initial begin
        dir = '{
            '{1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 32'h40000000, 4},
            '{1'b0, 8'h04, 32'h00000000, 1'b0, 1'b0, 32'h60000000, 5},
            '{1'b1, 8'h00, 32'h00000000, 1'b0, 1'b0, 32'hC0000000, 4},
            '{1'b0, 8'hFF, 32'h00000000, 1'b0, 1'b0, 32'h38000000, 4},
            '{1'b0, 8'h00, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h48000000, 4},
            '{1'b0, 8'h7F, 32'h00000000, 1'b0, 1'b0, 32'h7FFFFFFF, 3},
            '{1'b0, 8'h80, 32'h00000000, 1'b0, 1'b0, 32'h00000001, 3},
            '{1'b1, 8'h7F, 32'h00000000, 1'b0, 1'b0, 32'h80000001, 3},
            '{1'b0, 8'h84, 32'h00000000, 1'b0, 1'b0, 32'h00000001, 34},
            '{1'b1, 8'h84, 32'h00000000, 1'b0, 1'b0, 32'hFFFFFFFF, 34},
            '{1'b0, 8'h7B, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h7FFFFFFF, 34},
            '{1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 2},
            '{1'b0, 8'h00, 32'h00000000, 1'b1, 1'b1, 32'h80000000, 2}
        };

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", out, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        foreach (dir[j]) begin
            run_op(dir[j].s, dir[j].sc, dir[j].fr, dir[j].z, dir[j].i,
                   $sformatf("dir%0d", j), o, lat);
            chk($sformatf("dir%0d_out", j), o, dir[j].exp);
            chk($sformatf("dir%0d_lat", j), 32'(lat), 32'(dir[j].lat));
        end

        // start held high across several operations
        @(negedge clk);
        sign = 1'b0; scale = 8'h00; frac = '0; zero_in = 1'b0; inf_in = 1'b0;
        start = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) cnt++;
        end
        start = 1'b0;
        chk("hold_done_count", 32'(cnt), 32'd5);
        chk("hold_out", out, 32'h40000000);
        repeat (6) @(negedge clk);

        // reset in the middle of SHIFT
        @(negedge clk);
        scale = 8'd40; frac = 32'h12345678; sign = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", out, 32'h0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("midrst_no_done", 32'(cnt), 32'd0);
        chk("midrst_out_after", out, 32'h0);
        run_op(1'b0, 8'h04, 32'h0, 1'b0, 1'b0, "postrst", o, lat);
        chk("postrst_out", o, 32'h60000000);
        chk("postrst_lat", 32'(lat), 32'd5);

        // randomized against the reference model
        for (int t = 0; t < 80; t++) begin
            logic        rs;
            logic [7:0]  rsc;
            logic [31:0] rfr;
            logic        rz;
            logic        ri;
            int          mode;
            rs   = 1'($urandom_range(0, 1));
            rsc  = 8'($urandom_range(0, 255));
            mode = $urandom_range(0, 3);
            rfr  = (mode == 0) ? 32'h0 : (mode == 1) ? 32'hFFFFFFFF : $urandom;
            rz   = ($urandom_range(0, 15) == 0);
            ri   = ($urandom_range(0, 15) == 0);
            e_out = ref_enc(rs, rsc, rfr, rz, ri, e_lat);
            run_op(rs, rsc, rfr, rz, ri, $sformatf("rnd%0d", t), o, lat);
            chk($sformatf("rnd%0d_out", t), o, e_out);
            chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'(e_lat));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/posit_encode_seq.md
POSIT_ENCODE_SEQ -- requirements
Module: posit_encode_seq

Interface
REQ-001 Parameters: N, default 32, posit width; es, default 2, exponent field width; SW, default 8, scale input width.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 sign  input  1  value sign.
REQ-006 scale  input  SW  signed two's-complement total scale, k*2^es + e.
REQ-007 frac  input  N  fraction bits below the hidden 1, MSB-aligned.
REQ-008 zero_in, inf_in  input  1 each  special-value flags; inf_in has priority.
REQ-009 out  output  N  encoded posit; holds its value between results.
REQ-010 busy  output  1  high in every non-IDLE state.
REQ-011 done  output  1  one-cycle pulse; out is valid in the same cycle.

Function
REQ-012 FSM states are IDLE, SHIFT, ROUND, FIN; FIN returns to IDLE on the next edge.
REQ-013 On IDLE with start=1, capture the inputs and form k = scale>>>es, e = scale[es-1:0], and R = k+1 (k>=0) or -k (k<0).
REQ-014 Load a 2N-bit working register W = {term, e, frac, zeros}, with term=0 for k>=0 and term=1 for k<0.
REQ-015 SHIFT shifts W right one bit per cycle, inserting fill (1 for k>=0, 0 for k<0) at the MSB, for exactly R cycles.
REQ-016 If R > N-1, skip SHIFT, set out = maxpos (k>=0) or minpos (k<0) with sign applied, and go through ROUND to FIN.
REQ-017 ROUND: body = W[2N-1:N+1] (N-1 bits), guard = W[N], sticky = OR of W[N-1:0]; round-to-nearest-even.
REQ-018 A rounded body is clamped to 0x..01 minimum and all-ones maximum; a nonzero value never encodes to zero or NaR.
REQ-019 sign=1 yields the two's complement of {0, body}.
REQ-020 inf_in: out = 1 followed by N-1 zeros. Otherwise zero_in: out = 0. Both go IDLE -> FIN directly, so done pulses 2 edges after the start edge.
REQ-021 Latency is R+3 edges from the start edge to done high (SHIFT R, ROUND 1, FIN 1). The saturation path of REQ-016 takes 3.
REQ-022 start is ignored while busy=1. start in the FIN cycle is also ignored; the next start is accepted in IDLE.
REQ-023 out updates only on entry to FIN; done is high exactly in FIN.

Reset
REQ-024 rst_n low asynchronously forces the state to IDLE and sets out=0, done=0, busy=0, W=0, and the counter to 0.
REQ-025 A reset asserted mid-operation aborts the operation with no done pulse; the first start after release is processed normally.

Configuration
REQ-026 Macro POSIT_ENC_OVF_FLAG_EN, when defined, adds output ovf (1 bit, reset 0). ovf is high with done when REQ-016 saturation or the REQ-018 clamp occurred, and is low otherwise.
REQ-027 Without POSIT_ENC_OVF_FLAG_EN the ovf port and its logic are absent; saturation and clamp behaviour are unchanged.

Verification (N=32, es=2)
REQ-028 sign=0, scale=0, frac=0 -> out=0x40000000, done 4 edges after start.
REQ-029 scale=4 -> 0x60000000, latency 5. sign=1, scale=0 -> 0xC0000000. scale=-1 -> 0x38000000, latency 4.
REQ-030 scale=0, frac=0xFFFFFFFF -> round-up carry -> 0x48000000.
REQ-031 scale=127 -> 0x7FFFFFFF with ovf=1 (macro on), latency 3. scale=-128 -> 0x00000001.
REQ-032 zero_in=1 -> 0x00000000 after 2 edges. inf_in=1 and zero_in=1 -> 0x80000000.
REQ-033 rst_n pulsed low during SHIFT -> no done, out=0. start held high during busy -> exactly one done per accepted start.
